// File: rtl/regwr_pipe_ctrl.sv
// Pipelined register-write controller: decodes write enable/destination, carries them to writeback,
// and reports RAW hazards, pending writes and illegal opcodes. Optional forwarding selects: REGWR_FORWARD_EN.
module regwr_pipe_ctrl #(
   parameter int STAGES = 3,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             valid_in,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic [4:0]       rs,
   input  logic [4:0]       rt,
   input  logic [4:0]       rd,
   input  logic             stall,
   input  logic             flush,
   output logic             regwr_wb,
   output logic [4:0]       waddr_wb,
   output logic             hazard_rs,
   output logic             hazard_rt,
   output logic [3:0]       pending,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic [3:0]       fwd_rs_sel,
   output logic [3:0]       fwd_rt_sel
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   logic             w_wr_raw;
   logic             w_wr;
   logic [4:0]       w_dest;
   logic             w_illegal;
   logic             w_cnt_inc;

   logic             r_v [STAGES];
   logic             r_w [STAGES];
   logic [4:0]       r_a [STAGES];
   logic             w_nv [STAGES];
   logic             w_nw [STAGES];
   logic [4:0]       w_na [STAGES];

   logic [3:0]       w_pend_nxt;
   logic [3:0]       r_pending;
   logic             r_wb_en;
   logic [4:0]       r_wb_addr;
   logic [CNT_W-1:0] r_illegal_cnt;
   logic [STAGES-1:0] w_m_rs;
   logic [STAGES-1:0] w_m_rt;

   // Instruction decode: write enable, destination and illegal flag
   always_comb begin
      w_wr_raw  = 1'b0;
      w_dest    = 5'd0;
      w_illegal = 1'b0;
      case (opcode)
         OP_LW, OP_XORI, OP_ADDI: begin
            w_wr_raw = 1'b1;
            w_dest   = rt;
         end
         OP_JAL: begin
            w_wr_raw = 1'b1;
            w_dest   = 5'd31;
         end
         OP_SW, OP_J, OP_BEQ, OP_BNE: begin
            w_wr_raw = 1'b0;
         end
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_SLT: begin
                  w_wr_raw = 1'b1;
                  w_dest   = rd;
               end
               FN_JR:   w_wr_raw  = 1'b0;
               default: w_illegal = 1'b1;
            endcase
         end
         default: w_illegal = 1'b1;
      endcase
   end

   // r0 is hardwired, so a write to it is dropped at decode
   assign w_wr      = w_wr_raw & (w_dest != 5'd0);
   assign w_cnt_inc = valid_in & ~stall & ~flush & w_illegal;

   // Next pipe contents: shift, then apply stall/flush to the two youngest stages
   always_comb begin
      for (int k = 1; k < STAGES; k++) begin
         w_nv[k] = r_v[k-1];
         w_nw[k] = r_w[k-1];
         w_na[k] = r_a[k-1];
      end
      if (flush) begin
         w_nv[0] = 1'b0;
         w_nw[0] = 1'b0;
         w_na[0] = 5'd0;
         w_nv[1] = 1'b0;
         w_nw[1] = 1'b0;
         w_na[1] = 5'd0;
      end else if (stall) begin
         w_nv[0] = r_v[0];
         w_nw[0] = r_w[0];
         w_na[0] = r_a[0];
         w_nv[1] = 1'b0;
         w_nw[1] = 1'b0;
         w_na[1] = 5'd0;
      end else begin
         w_nv[0] = valid_in;
         w_nw[0] = valid_in & w_wr;
         w_na[0] = valid_in ? w_dest : 5'd0;
      end
   end

   // Pending-write count of the next pipe contents
   always_comb begin
      w_pend_nxt = 4'd0;
      for (int k = 0; k < STAGES; k++) begin
         w_pend_nxt = w_pend_nxt + {3'b000, w_nv[k] & w_nw[k]};
      end
   end

   // Pipe stages, writeback outputs, pending count and illegal counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k] <= 1'b0;
            r_w[k] <= 1'b0;
            r_a[k] <= 5'd0;
         end
         r_pending     <= 4'd0;
         r_wb_en       <= 1'b0;
         r_wb_addr     <= 5'd0;
         r_illegal_cnt <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k] <= w_nv[k];
            r_w[k] <= w_nw[k];
            r_a[k] <= w_na[k];
         end
         r_pending <= w_pend_nxt;
         r_wb_en   <= w_nv[STAGES-1] & w_nw[STAGES-1];
         r_wb_addr <= (w_nv[STAGES-1] & w_nw[STAGES-1]) ? w_na[STAGES-1] : 5'd0;
         if (w_cnt_inc && (r_illegal_cnt != {CNT_W{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_illegal_cnt <= r_illegal_cnt;
         end
      end
   end

   // Per-stage address match against the current source registers
   always_comb begin
      w_m_rs = '0;
      w_m_rt = '0;
      for (int k = 0; k < STAGES; k++) begin
         w_m_rs[k] = r_v[k] & r_w[k] & (r_a[k] == rs);
         w_m_rt[k] = r_v[k] & r_w[k] & (r_a[k] == rt);
      end
   end

   assign hazard_rs = valid_in & (rs != 5'd0) & (|w_m_rs);
   assign hazard_rt = valid_in & (rt != 5'd0) & (|w_m_rt);

`ifdef REGWR_FORWARD_EN
   // Forwarding select: scan oldest to youngest so the youngest match wins
   always_comb begin
      fwd_rs_sel = 4'd0;
      fwd_rt_sel = 4'd0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (w_m_rs[k] && (rs != 5'd0)) begin
            fwd_rs_sel = 4'(k + 1);
         end else begin
            fwd_rs_sel = fwd_rs_sel;
         end
         if (w_m_rt[k] && (rt != 5'd0)) begin
            fwd_rt_sel = 4'(k + 1);
         end else begin
            fwd_rt_sel = fwd_rt_sel;
         end
      end
   end
`else
   assign fwd_rs_sel = 4'd0;
   assign fwd_rt_sel = 4'd0;
`endif

   assign regwr_wb    = r_wb_en;
   assign waddr_wb    = r_wb_addr;
   assign pending     = r_pending;
   assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_regwr_pipe_ctrl.sv
// Directed self-checking bench for regwr_pipe_ctrl (STAGES=3, CNT_W=8).
module tb_regwr_pipe_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       valid_in;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rs, rt, rd;
   logic       stall, flush;
   logic       regwr_wb;
   logic [4:0] waddr_wb;
   logic       hazard_rs, hazard_rt;
   logic [3:0] pending;
   logic [7:0] illegal_cnt;
   logic [3:0] fwd_rs_sel, fwd_rt_sel;

   int n_chk  = 0;
   int n_pass = 0;

`ifdef REGWR_FORWARD_EN
   localparam logic [3:0] FWD1 = 4'd1;
   localparam logic [3:0] FWD2 = 4'd2;
`else
   localparam logic [3:0] FWD1 = 4'd0;
   localparam logic [3:0] FWD2 = 4'd0;
`endif

   regwr_pipe_ctrl #(.STAGES(3), .CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .opcode(opcode), .funct(funct),
      .rs(rs), .rt(rt), .rd(rd), .stall(stall), .flush(flush),
      .regwr_wb(regwr_wb), .waddr_wb(waddr_wb), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
      .pending(pending), .illegal_cnt(illegal_cnt), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic st, input logic fl);
      valid_in = v; opcode = op; funct = fn; rs = s; rt = t; rd = d; stall = st; flush = fl;
   endtask

   task automatic idle();
      drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wb(input string tag, input logic en, input logic [4:0] a, input logic [3:0] p);
      check({tag, ".wb"},    32'(regwr_wb), 32'(en));
      check({tag, ".waddr"}, 32'(waddr_wb), 32'(a));
      check({tag, ".pend"},  32'(pending),  32'(p));
   endtask

   logic [5:0] nw_op [6];
   logic [5:0] nw_fn [6];

   initial begin
      nw_op[0] = 6'h2B; nw_fn[0] = 6'h00;
      nw_op[1] = 6'h02; nw_fn[1] = 6'h00;
      nw_op[2] = 6'h04; nw_fn[2] = 6'h00;
      nw_op[3] = 6'h05; nw_fn[3] = 6'h00;
      nw_op[4] = 6'h00; nw_fn[4] = 6'h08;
      nw_op[5] = 6'h08; nw_fn[5] = 6'h00;

      reset_n = 1'b0;
      idle();
      #12;
      chk_wb("reset", 1'b0, 5'd0, 4'd0);
      check("reset.cnt", 32'(illegal_cnt), 32'd0);
      check("reset.fwd", 32'(fwd_rs_sel), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      step();

      // ADD rd=5: three edges to writeback
      drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
      step(); idle();
      chk_wb("add.e1", 1'b0, 5'd0, 4'd1);
      step();
      chk_wb("add.e2", 1'b0, 5'd0, 4'd1);
      step();
      chk_wb("add.e3", 1'b1, 5'd5, 4'd1);
      step();
      chk_wb("add.e4", 1'b0, 5'd0, 4'd0);

      // Non-writing sequence, then ADDI to r0
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, nw_op[i], nw_fn[i], 5'd3, 5'd0, 5'd4, 1'b0, 1'b0);
         step();
         chk_wb("nowr", 1'b0, 5'd0, 4'd0);
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         check("nowr.drain", 32'(regwr_wb), 32'd0);
      end

      // JAL then ADD rs=31: hazard and forwarding
      drive(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, 6'h00, 6'h20, 5'd31, 5'd7, 5'd3, 1'b0, 1'b0);
      #1;
      check("jal.hz_rs", 32'(hazard_rs), 32'd1);
      check("jal.hz_rt", 32'(hazard_rt), 32'd0);
      check("jal.fwd1", 32'(fwd_rs_sel), 32'(FWD1));
      check("jal.fwd_rt", 32'(fwd_rt_sel), 32'd0);
      valid_in = 1'b0;
      #1;
      check("jal.hz_novalid", 32'(hazard_rs), 32'd0);
      step();
      valid_in = 1'b1;
      #1;
      check("jal.fwd2", 32'(fwd_rs_sel), 32'(FWD2));
      check("jal.hz2", 32'(hazard_rs), 32'd1);
      idle();
      step();
      chk_wb("jal.wb", 1'b1, 5'd31, 4'd1);
      step();
      chk_wb("jal.drain", 1'b0, 5'd0, 4'd0);

      // LW rt=9 with a two-cycle stall: writeback after five edges
      drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      step();
      chk_wb("stall.e2", 1'b0, 5'd0, 4'd1);
      step();
      chk_wb("stall.e3", 1'b0, 5'd0, 4'd1);
      check("stall.nocnt", 32'(illegal_cnt), 32'd0);
      idle();
      step();
      chk_wb("stall.e4", 1'b0, 5'd0, 4'd1);
      step();
      chk_wb("stall.e5", 1'b1, 5'd9, 4'd1);
      step();
      chk_wb("stall.e6", 1'b0, 5'd0, 4'd0);

      // Flush with stall drops the held LW
      drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
      step();
      drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      step();
      check("flush.pend", 32'(pending), 32'd0);
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         check("flush.nowb", 32'(regwr_wb), 32'd0);
      end

      // Flushed illegal opcode does not count; then 260 illegal opcodes saturate
      drive(1'b1, 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      step();
      check("ill.flushed", 32'(illegal_cnt), 32'd0);
      flush = 1'b0;
      for (int i = 1; i <= 260; i++) begin
         step();
         if (i == 1)   check("ill.1", 32'(illegal_cnt), 32'd1);
         if (i == 254) check("ill.254", 32'(illegal_cnt), 32'd254);
         if (i == 255) check("ill.255", 32'(illegal_cnt), 32'd255);
         if (i == 260) check("ill.sat", 32'(illegal_cnt), 32'd255);
      end
      check("ill.pend", 32'(pending), 32'd0);

      // Three writes in flight, then asynchronous reset mid-cycle
      drive(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
      step();
      drive(1'b1, 6'h00, 6'h22, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
      step();
      drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
      step();
      chk_wb("rst.pre", 1'b1, 5'd5, 4'd3);
      drive(1'b1, 6'h00, 6'h20, 5'd6, 5'd9, 5'd1, 1'b0, 1'b0);
      #1;
      check("rst.pre_hz", 32'(hazard_rs), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk_wb("rst.async", 1'b0, 5'd0, 4'd0);
      check("rst.cnt", 32'(illegal_cnt), 32'd0);
      check("rst.hz_rs", 32'(hazard_rs), 32'd0);
      check("rst.hz_rt", 32'(hazard_rt), 32'd0);
      idle();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_wb("rst.post", 1'b0, 5'd0, 4'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/regwr_pipe_ctrl.md
Name: regwr_pipe_ctrl

Overview:
- Pipelined successor to the single-cycle register-write decoder.
- Decodes opcode/funct into a write-enable and a destination register, then carries that pair through a parametrised number of pipeline stages to writeback.
- Tracks in-flight writes for RAW hazard detection, supports stall and flush, and counts illegal instructions.
- Sits between fetch/decode and the register file of the pipelined CPU.

Parameters:
- STAGES, 3, pipeline depth from decode capture to writeback; legal range 2..8.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  instruction fields are valid this cycle.
- opcode  in  6  instruction opcode.
- funct  in  6  R-type function field.
- rs  in  5  source register 1.
- rt  in  5  source register 2 / I-type destination.
- rd  in  5  R-type destination.
- stall  in  1  hold the decode capture and insert a bubble.
- flush  in  1  discard the incoming instruction and the youngest stage.
- regwr_wb  out  1  write enable at writeback (last stage).
- waddr_wb  out  5  write address at writeback.
- hazard_rs  out  1  rs matches a pending write.
- hazard_rt  out  1  rt matches a pending write.
- pending  out  4  number of valid writing entries in the pipe.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal opcodes.
- fwd_rs_sel  out  4  forwarding select for rs (see Optional Feature).
- fwd_rt_sel  out  4  forwarding select for rt (see Optional Feature).

Behaviour:
- Encodings come from the CPU.v macros.
  - Opcodes: LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, XORI 0x0E, ADDI 0x08, RTYPE 0x00.
  - Functs: JR 0x08, ADD 0x20, SUB 0x22, SLT 0x2A.
- Decode (combinational):
  - Writing instructions: LW, XORI, ADDI (dest = rt); ADD, SUB, SLT (dest = rd); JAL (dest = 31).
  - Non-writing: SW, J, BEQ, BNE, JR.
  - Any other opcode, or RTYPE with an unlisted funct, is illegal and does not write.
  - A destination of 0 forces the write enable to 0.
- Pipe state: stage[k] = {valid, wr, waddr}, k = 0..STAGES-1.
  - Stage 0 is the youngest; stage STAGES-1 drives the writeback outputs.
- Each clock edge:
  - Stages 1..STAGES-1 always take the previous stage's contents.
  - Normal: stage 0 takes the decoded instruction when valid_in=1, otherwise a bubble.
  - stall=1, flush=0: stage 0 holds its value and stage 1 takes a bubble.
  - flush=1: stage 0 takes a bubble, stage 1 takes a bubble, and the input is discarded. Flush overrides stall.
- Latency: an instruction accepted at edge t appears on regwr_wb/waddr_wb after edge t+STAGES-1. This equals STAGES cycles from presentation when there is no stall.
- Writeback outputs: regwr_wb = valid & wr of the last stage; waddr_wb = that stage's waddr, or 0 when regwr_wb=0.
- Hazards (combinational, from the current rs/rt and all stages):
  - hazard_rs=1 iff rs≠0 and some stage has valid & wr & waddr==rs; hazard_rt is the same for rt.
  - Both outputs are 0 when valid_in=0.
- pending: number of stages with valid & wr, registered and consistent with the stage contents after each edge.
- illegal_cnt: increments when an illegal instruction is captured into stage 0 (valid_in=1, stall=0, flush=0). It saturates at all-ones and does not wrap.
- Reset (asynchronous, reset_n=0):
  - All stages become bubbles.
  - regwr_wb=0, waddr_wb=0, pending=0, illegal_cnt=0, fwd_*_sel=0.
  - Hazard outputs are 0 while reset is asserted.
  - Reset asserted mid-stream drops all in-flight writes; no writeback occurs on or after the reset edge.

Optional Feature:
- Macro REGWR_FORWARD_EN.
- Defined:
  - fwd_rs_sel = k+1, where k is the youngest stage with valid & wr & waddr==rs (and rs≠0); 0 if there is no match.
  - fwd_rt_sel follows the same rule for rt.
  - Youngest wins when several stages match.
- Undefined: both select outputs are tied to 0 and no compare-priority logic is built. Hazard outputs are unaffected either way.

Test Plan:
- Reset, then ADD rd=5 with valid_in=1 at cycle 0 -> regwr_wb=1 and waddr_wb=5 exactly at cycle STAGES (3); pending goes 1,1,1, then 0 once it drains.
- Sequence SW, J, BEQ, BNE, JR, then ADDI rt=0 -> regwr_wb stays 0 throughout, pending stays 0.
- JAL, then next cycle ADD rs=31 rt=7 -> hazard_rs=1, hazard_rt=0; with REGWR_FORWARD_EN, fwd_rs_sel=1.
- LW rt=9, then stall held for 2 cycles -> stage-1 bubbles appear and LW writes back at cycle STAGES+2; flush asserted with stall discards the held LW and regwr_wb never asserts for it.
- Feed 260 illegal opcodes (0x3F) with CNT_W=8 -> illegal_cnt saturates at 255; flushed illegal opcodes do not count.
- Assert reset_n=0 asynchronously mid-cycle with 3 writes in flight -> outputs are 0 immediately; after release, no stale writeback and pending=0.
